// File: rtl/mips32_pkg.sv
// Opcode constants, decode classes and pipeline-register layouts shared by the
// ID-stage interlock and its bench-facing top.
package mips32_pkg;

  localparam logic [5:0] OP_RR_ALU = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b001000;
  localparam logic [5:0] OP_SW     = 6'b001001;
  localparam logic [5:0] OP_BNEQZ  = 6'b001101;
  localparam logic [5:0] OP_BEQZ   = 6'b001110;
  localparam logic [5:0] OP_HLT    = 6'b111111;

  typedef enum logic [2:0] {
    CLS_RR_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_HALT,
    CLS_OTHER
  } instr_class_e;

  typedef enum logic [1:0] {
    HAZ_NONE,
    HAZ_LOAD_USE,
    HAZ_BRANCH,
    HAZ_HALTED
  } hazard_class_e;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } run_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] npc;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } idex_t;

  function automatic instr_class_e classify(input logic [5:0] op);
    instr_class_e cls;
    case (op)
      OP_RR_ALU:         cls = CLS_RR_ALU;
      OP_LW:             cls = CLS_LOAD;
      OP_SW:             cls = CLS_STORE;
      OP_BNEQZ, OP_BEQZ: cls = CLS_BRANCH;
      OP_HLT:            cls = CLS_HALT;
      default:           cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two combinational read ports, one write port.
// R0 reads as zero; a same-cycle write is forwarded to the read ports.
module regfile_2r1w (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);

  logic [31:0] mem_q [32];

  // Storage is intentionally not reset; only the pipeline control is.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    if (raddr_a_i == 5'd0) begin
      rdata_a_o = '0;
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = mem_q[raddr_b_i];
    if (raddr_b_i == 5'd0) begin
      rdata_b_o = '0;
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/pipe_id_interlock.sv
// IF/ID + ID/EX registers with load-use / branch interlock, ID-stage branch
// resolution and sticky HLT. Optional stall counter under LOADUSE_STALL_CNT_EN.
//
// state     | meaning
// ST_RUN    | normal issue from ID
// ST_HALTED | HLT has left ID; stall held until reset
module pipe_id_interlock
  import mips32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_npc,
  input  logic        if_valid,
  input  logic        ex_wr_en,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_dst,
  input  logic        mem_wr_en,
  input  logic [4:0]  mem_dst,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        idex_valid,
  output logic [5:0]  idex_op,
  output logic [4:0]  idex_rs,
  output logic [4:0]  idex_rt,
  output logic [4:0]  idex_rd,
  output logic [31:0] idex_a,
  output logic [31:0] idex_b,
  output logic [31:0] idex_imm,
  output logic [31:0] idex_npc,
`ifdef LOADUSE_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        halted
);

  ifid_t         ifid_q, ifid_d;
  idex_t         idex_q, idex_d;
  run_state_e    state_q, state_d;
  hazard_class_e haz;

  logic [5:0]    id_op;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [31:0]   id_imm;
  instr_class_e  id_cls;
  logic [31:0]   rf_a, rf_b;
  logic          uses_rt, load_use, br_dep, br_cond, hlt_issue;

  assign id_op  = ifid_q.instr[31:26];
  assign id_rs  = ifid_q.instr[25:21];
  assign id_rt  = ifid_q.instr[20:16];
  assign id_rd  = ifid_q.instr[15:11];
  assign id_imm = sext16(ifid_q.instr[15:0]);
  assign id_cls = classify(id_op);

  regfile_2r1w u_regfile (
    .clk       (clk),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (id_rs),
    .raddr_b_i (id_rt),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  // Branches compare in ID, so they also wait for EX/MEM writers of rs.
  always_comb begin
    uses_rt  = (id_cls == CLS_RR_ALU) || (id_cls == CLS_STORE);
    load_use = ifid_q.valid && ex_is_load && (ex_dst != 5'd0) &&
               ((ex_dst == id_rs) || (uses_rt && (ex_dst == id_rt)));
    br_dep   = ifid_q.valid && (id_cls == CLS_BRANCH) && (id_rs != 5'd0) &&
               ((ex_wr_en && (ex_dst == id_rs)) || (mem_wr_en && (mem_dst == id_rs)));
    haz = HAZ_NONE;
    if (state_q == ST_HALTED) begin
      haz = HAZ_HALTED;
    end else if (load_use) begin
      haz = HAZ_LOAD_USE;
    end else if (br_dep) begin
      haz = HAZ_BRANCH;
    end
  end

  assign stall     = (haz != HAZ_NONE);
  assign br_cond   = ((id_op == OP_BEQZ) && (rf_a == 32'd0)) ||
                     ((id_op == OP_BNEQZ) && (rf_a != 32'd0));
  assign br_taken  = ifid_q.valid && !stall && br_cond;
  assign br_target = ifid_q.npc + id_imm;
  assign hlt_issue = ifid_q.valid && (id_cls == CLS_HALT) && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (hlt_issue) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    halted = (state_q == ST_HALTED);
  end

  always_comb begin
    ifid_d = ifid_q;
    if (br_taken) begin
      ifid_d.valid = 1'b0;
    end else if (!stall) begin
      ifid_d.valid = if_valid;
      ifid_d.instr = if_instr;
      ifid_d.npc   = if_npc;
    end
  end

  always_comb begin
    idex_d.valid = ifid_q.valid && !stall;
    idex_d.op    = id_op;
    idex_d.rs    = id_rs;
    idex_d.rt    = id_rt;
    idex_d.rd    = id_rd;
    idex_d.a     = rf_a;
    idex_d.b     = rf_b;
    idex_d.imm   = id_imm;
    idex_d.npc   = ifid_q.npc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_q <= '0;
      idex_q <= '0;
    end else begin
      ifid_q <= ifid_d;
      idex_q <= idex_d;
    end
  end

  assign idex_valid = idex_q.valid;
  assign idex_op    = idex_q.op;
  assign idex_rs    = idex_q.rs;
  assign idex_rt    = idex_q.rt;
  assign idex_rd    = idex_q.rd;
  assign idex_a     = idex_q.a;
  assign idex_b     = idex_q.b;
  assign idex_imm   = idex_q.imm;
  assign idex_npc   = idex_q.npc;

`ifdef LOADUSE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_id_interlock.sv
// Bench for pipe_id_interlock: directed pipeline scenarios plus a randomized
// run against a rule-level reference model of the ID stage.
module tb_pipe_id_interlock;

  localparam logic [5:0] T_RR = 6'b000000, T_LW = 6'b001000, T_SW = 6'b001001;
  localparam logic [5:0] T_BNEQZ = 6'b001101, T_BEQZ = 6'b001110, T_HLT = 6'b111111;

  logic        clk, reset;
  logic [31:0] if_instr, if_npc;
  logic        if_valid;
  logic        ex_wr_en, ex_is_load;
  logic [4:0]  ex_dst;
  logic        mem_wr_en;
  logic [4:0]  mem_dst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall, br_taken, idex_valid, halted;
  logic [31:0] br_target, idex_a, idex_b, idex_imm, idex_npc;
  logic [5:0]  idex_op;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
`ifdef LOADUSE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] m_regs [32];
  logic [31:0] ld_value;

  pipe_id_interlock dut (
    .clk(clk), .reset(reset),
    .if_instr(if_instr), .if_npc(if_npc), .if_valid(if_valid),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_dst(ex_dst),
    .mem_wr_en(mem_wr_en), .mem_dst(mem_dst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .idex_valid(idex_valid), .idex_op(idex_op), .idex_rs(idex_rs),
    .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_a(idex_a), .idex_b(idex_b),
    .idex_imm(idex_imm), .idex_npc(idex_npc),
`ifdef LOADUSE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    if_instr = '0; if_npc = '0; if_valid = 1'b0;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_dst = '0;
    mem_wr_en = 1'b0; mem_dst = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic preload();
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      m_regs[r] = (r == 7) ? 32'd0 : (r == 4) ? 32'hDEAD_0004 : $urandom;
      wb_we = 1'b1; wb_addr = 5'(r); wb_data = m_regs[r];
    end
    @(negedge clk);
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  // The bench plays EX/MEM/WB: whatever sits in ID/EX writes back two edges later.
  task automatic pipe_tick();
    logic        nxt_wr;
    logic [4:0]  nxt_dst;
    logic [31:0] nxt_data;
    nxt_wr   = ex_wr_en;
    nxt_dst  = ex_dst;
    nxt_data = ex_is_load ? ld_value : (idex_a + idex_b);
    @(posedge clk);
    #1;
    mem_wr_en = nxt_wr; mem_dst = nxt_dst;
    wb_we = nxt_wr; wb_addr = nxt_dst; wb_data = nxt_data;
    ex_wr_en   = idex_valid && ((idex_op == T_RR) || (idex_op == T_LW));
    ex_is_load = idex_valid && (idex_op == T_LW);
    ex_dst     = (idex_op == T_LW) ? idex_rt : idex_rd;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #3;
    checks++;
    if ({stall, br_taken, halted, idex_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: stall/br/halted/valid=%b expected 0000", {stall, br_taken, halted, idex_valid});
    end
    checks++;
    if ({idex_op, idex_rs, idex_rt, idex_rd, idex_a, idex_b, idex_imm, idex_npc} !== '0) begin
      errors++;
      $display("FAIL reset_fields: op=%h a=%h b=%h imm=%h npc=%h expected all zero", idex_op, idex_a, idex_b, idex_imm, idex_npc);
    end
`ifdef LOADUSE_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    int bubbles = 0;
    bit seen = 0;
    ld_value = 32'd8;
    if_instr = 32'h2041_0000; if_npc = 32'h40; if_valid = 1'b1;
    pipe_tick();
    if_instr = 32'h0023_2800; if_npc = 32'h41;
    pipe_tick();
    if_valid = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      #1;
      if (stall) bubbles++;
      pipe_tick();
      if (idex_valid && (idex_op == T_RR)) seen = 1;
    end
    checks++;
    if (!seen || bubbles != 1) begin
      errors++;
      $display("FAIL load_use_bubbles: seen=%0d bubbles=%0d expected seen=1 bubbles=1", seen, bubbles);
    end
    checks++;
    if (idex_rs !== 5'd1 || idex_a !== 32'd8 || idex_rd !== 5'd5) begin
      errors++;
      $display("FAIL load_use_operand: rs=%0d a=%h rd=%0d expected rs=1 a=8 rd=5", idex_rs, idex_a, idex_rd);
    end
  endtask

  task automatic test_branch_after_load();
    int stalls = 0;
    bit taken = 0;
    logic [31:0] tgt = '0;
    ld_value = 32'd0;
    if_instr = 32'h216A_0000; if_npc = 32'h80; if_valid = 1'b1;
    pipe_tick();
    if_instr = 32'h3940_0005; if_npc = 32'h100;
    pipe_tick();
    if_instr = 32'h0023_2800; if_npc = 32'h101;
    for (int c = 0; c < 6 && !taken; c++) begin
      #1;
      if (stall) stalls++;
      else if (br_taken) begin
        taken = 1;
        tgt = br_target;
      end
      pipe_tick();
    end
    checks++;
    if (stalls != 2 || !taken) begin
      errors++;
      $display("FAIL branch_stalls: stalls=%0d taken=%0d expected 2 and 1", stalls, taken);
    end
    checks++;
    if (tgt !== 32'h105) begin
      errors++;
      $display("FAIL branch_target: got %h expected 00000105", tgt);
    end
    if_valid = 1'b0;
    pipe_tick();
    checks++;
    if (idex_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_flush: idex_valid=%b expected 0", idex_valid);
    end
`ifdef LOADUSE_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd3) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_no_dep_branch();
    if_instr = 32'h0023_2800; if_npc = 32'h200; if_valid = 1'b1;
    pipe_tick();
    if_instr = 32'h34E0_0003; if_npc = 32'h201;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL nodep_add_stall: got %b expected 0", stall);
    end
    pipe_tick();
    if_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || br_taken !== 1'b0) begin
      errors++;
      $display("FAIL nodep_bneqz: stall=%b br_taken=%b expected 0 0", stall, br_taken);
    end
    pipe_tick();
  endtask

  task automatic test_wb_bypass();
    if_instr = 32'h0080_0000; if_npc = 32'h300; if_valid = 1'b1;
    pipe_tick();
    if_valid = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'd13;
    pipe_tick();
    checks++;
    if (idex_valid !== 1'b1 || idex_a !== 32'd13) begin
      errors++;
      $display("FAIL wb_bypass: valid=%b a=%h expected 1 0000000d", idex_valid, idex_a);
    end
  endtask

  task automatic test_halt();
    if_instr = 32'hFC00_0000; if_npc = 32'h400; if_valid = 1'b1;
    pipe_tick();
    if_instr = 32'h0023_2800; if_npc = 32'h401;
    pipe_tick();
    checks++;
    if (idex_valid !== 1'b1 || idex_op !== T_HLT || halted !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL halt_issue: valid=%b op=%h halted=%b stall=%b expected 1 3f 1 1", idex_valid, idex_op, halted, stall);
    end
    for (int c = 0; c < 3; c++) begin
      pipe_tick();
      checks++;
      if (idex_valid !== 1'b0 || halted !== 1'b1 || stall !== 1'b1) begin
        errors++;
        $display("FAIL halt_sticky: valid=%b halted=%b stall=%b expected 0 1 1", idex_valid, halted, stall);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: halted=%b stall=%b expected 0 0", halted, stall);
    end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_midflight();
    ld_value = 32'd8;
    if_instr = 32'h2041_0000; if_npc = 32'h40; if_valid = 1'b1;
    pipe_tick();
    if_instr = 32'h0023_2800; if_npc = 32'h41;
    pipe_tick();
    if_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL midstall_pre: stall=%b expected 1", stall);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || br_taken !== 1'b0 || idex_valid !== 1'b0) begin
      errors++;
      $display("FAIL midstall_reset: stall=%b br=%b valid=%b expected 0 0 0", stall, br_taken, idex_valid);
    end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    pipe_tick();
    pipe_tick();
    checks++;
    if (idex_valid !== 1'b0) begin
      errors++;
      $display("FAIL midstall_discard: idex_valid=%b expected 0", idex_valid);
    end
    if_instr = 32'h38E0_0002; if_npc = 32'h500; if_valid = 1'b1;
    pipe_tick();
    if_valid = 1'b0;
    #1;
    checks++;
    if (br_taken !== 1'b1 || br_target !== 32'h502) begin
      errors++;
      $display("FAIL midbranch_pre: br=%b target=%h expected 1 00000502", br_taken, br_target);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (br_taken !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL midbranch_reset: br=%b stall=%b expected 0 0", br_taken, stall);
    end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && (wb_addr == r)) return wb_data;
    return m_regs[r];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [6] = '{T_RR, T_LW, T_SW, T_BNEQZ, T_BEQZ, 6'b001010};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 5)];
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  task automatic test_random();
    bit m_v = 0;
    logic [31:0] m_instr = '0, m_npc = '0;
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      logic [4:0] rs, rt;
      logic [31:0] av, bv, imm, tgt;
      bit uses_rt, is_br, e_stall, e_br, e_valid;
      @(negedge clk);
      if_valid = ($urandom_range(0, 3) != 0);
      if_instr = rand_instr();
      if_npc = $urandom;
      ex_wr_en = 1'($urandom); ex_is_load = 1'($urandom); ex_dst = 5'($urandom_range(0, 7));
      mem_wr_en = 1'($urandom); mem_dst = 5'($urandom_range(0, 7));
      wb_we = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      op = m_instr[31:26]; rs = m_instr[25:21]; rt = m_instr[20:16];
      uses_rt = (op == T_RR) || (op == T_SW);
      is_br = (op == T_BEQZ) || (op == T_BNEQZ);
      e_stall = m_v && ((ex_is_load && ex_dst != 0 && (ex_dst == rs || (uses_rt && ex_dst == rt))) ||
                        (is_br && rs != 0 && ((ex_wr_en && ex_dst == rs) || (mem_wr_en && mem_dst == rs))));
      av = ref_read(rs);
      bv = ref_read(rt);
      imm = {{16{m_instr[15]}}, m_instr[15:0]};
      tgt = m_npc + imm;
      e_br = m_v && !e_stall && ((op == T_BEQZ && av == 0) || (op == T_BNEQZ && av != 0));
      e_valid = m_v && !e_stall;
      checks++;
      if (stall !== e_stall || br_taken !== e_br) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: stall=%b br=%b expected %b %b", n, stall, br_taken, e_stall, e_br);
      end
      if (e_br) begin
        checks++;
        if (br_target !== tgt) begin
          errors++;
          $display("FAIL rand_target[%0d]: got %h expected %h", n, br_target, tgt);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (idex_valid !== e_valid) begin
        errors++;
        $display("FAIL rand_valid[%0d]: got %b expected %b", n, idex_valid, e_valid);
      end
      if (e_valid) begin
        checks++;
        if ({idex_op, idex_rs, idex_rt, idex_rd, idex_imm, idex_npc} !== {m_instr[31:11], imm, m_npc}) begin
          errors++;
          $display("FAIL rand_fields[%0d]: op=%h rs=%0d rt=%0d imm=%h npc=%h expected instr=%h npc=%h", n, idex_op, idex_rs, idex_rt, idex_imm, idex_npc, m_instr, m_npc);
        end
        checks++;
        if (idex_a !== av || idex_b !== bv) begin
          errors++;
          $display("FAIL rand_operands[%0d]: a=%h b=%h expected %h %h", n, idex_a, idex_b, av, bv);
        end
      end
      if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (e_br) begin
        m_v = 0;
      end else if (!e_stall) begin
        m_v = if_valid; m_instr = if_instr; m_npc = if_npc;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ld_value = '0;
    clear_inputs();
    test_reset();
    preload();
    test_load_use();
    test_branch_after_load();
    test_no_dep_branch();
    test_wb_bypass();
    test_halt();
    test_reset_midflight();
    do_reset();
    preload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_id_interlock.md
PIPE_ID_INTERLOCK -- requirements
Module: pipe_id_interlock

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 if_instr / if_npc / if_valid  input  32/32/1  fetched instruction, PC+1, fetch-valid.
REQ-004 ex_wr_en / ex_is_load / ex_dst  input  1/1/5  ID/EX-stage writer info.
REQ-005 mem_wr_en / mem_dst  input  1/5  EX/MEM-stage writer info.
REQ-006 wb_we / wb_addr / wb_data  input  1/5/32  register-file write port.
REQ-007 stall  output  1  freeze PC and fetch, combinational.
REQ-008 br_taken / br_target  output  1/32  redirect PC, combinational.
REQ-009 idex_valid / idex_op / idex_rs / idex_rt / idex_rd  output  1/6/5/5/5  registered ID/EX fields.
REQ-010 idex_a / idex_b / idex_imm / idex_npc  output  32 each  registered operands, sign-extended immediate, next PC.
REQ-011 halted  output  1  sticky, HLT retired from ID.

Function
REQ-012 IF/ID register SHALL capture the if_* inputs when stall=0, hold when stall=1, and load valid=0 when br_taken=1.
REQ-013 Decode: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=sext([15:0]).
REQ-014 Load-ALU hazard: stall SHALL be 1 when ex_is_load=1, ex_dst!=0, and ex_dst equals a used source (rs for all classes; rt also for RR-ALU and SW).
REQ-015 Branch hazard (BEQZ/BNEQZ compare rs in ID): stall SHALL be 1 when (ex_wr_en and ex_dst==rs) or (mem_wr_en and mem_dst==rs), rs!=0; load->branch therefore costs 2 bubbles.
REQ-016 While stall=1, the ID/EX register SHALL load idex_valid=0 (bubble); other fields don't-care.
REQ-017 Branch resolution without stall: br_taken=1 when BEQZ and A==0, or BNEQZ and A!=0; br_target=npc+imm, 32-bit wrap.
REQ-018 A and B SHALL read the register file, with WB write-through when wb_we=1 and wb_addr matches a nonzero source.
REQ-019 R0 SHALL always read 0; writes to R0 are ignored.
REQ-020 Latency: an unstalled instruction appears on idex_* exactly one cycle after it enters IF/ID.
REQ-021 HLT in ID SHALL pass to ID/EX once, then set halted=1 and force stall=1 permanently until reset.
REQ-022 Invalid IF/ID contents SHALL never cause stall, br_taken, or halted.
REQ-023 Stall and br_taken in the same cycle: stall wins and br_taken=0.

Reset
REQ-024 On reset low: IF/ID valid=0, idex_valid=0, all idex_* fields=0, halted=0; register-file contents are not reset.
REQ-025 Reset asserted mid-stall or mid-branch SHALL discard the in-flight instruction with no redirect.

Configuration
REQ-026 Macro LOADUSE_STALL_CNT_EN defined: adds output stall_cnt (32-bit), reset to 0, +1 per stall cycle, saturating at all-ones.
REQ-027 Macro undefined: no stall_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-028 Package mips32_pkg SHALL hold the opcode constants: RR_ALU=000000, LW=001000, SW=001001, BNEQZ=001101, BEQZ=001110, HLT=111111.
REQ-029 Package mips32_pkg SHALL also hold the instruction-class enum and the hazard-class enum.
REQ-030 The register file SHALL be sub-module regfile_2r1w (32x32, 2 read ports, 1 write port, write-through).

Verification
REQ-031 LW R1,0(R2) then ADD R5,R1,R3 (0x00232800) -> exactly 1 bubble; ADD is issued with idex_rs=1 and idex_a equal to the loaded value 8.
REQ-032 LW R10,0(R11) (loads 0) then BEQZ R10,5 (0x39400005) -> 2 stall cycles, then br_taken=1, br_target=npc+5; the following IF/ID slot is flushed.
REQ-033 ADD R5,R1,R3 then BNEQZ R7 (no dependency) -> stall=0 throughout; R7=0 gives br_taken=0.
REQ-034 wb_we=1, wb_addr=4, wb_data=13 in the same cycle an instruction with rs=4 is in ID -> idex_a=13.
REQ-035 HLT (0xfc000000) -> one valid HLT on idex, halted=1 and stall=1 afterwards; reset pulse clears both.
REQ-036 With LOADUSE_STALL_CNT_EN, the sequences of REQ-031 then REQ-032 -> stall_cnt=3.
